// File: rtl/cdc_xfer_scheduler_if.sv
// Requester-side and destination-side signals of the CDC transfer scheduler.
// The scheduler takes the slave modport. Its environment takes the master modport.
interface cdc_xfer_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
) ();
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic                      timeout_err;
  logic                      busy;
  logic [ID_W-1:0]           grant_id;
  logic                      xfer_req;
  logic [DATA_W-1:0]         xfer_data;
  logic                      xfer_ack_async;
  logic [2:0]                fsm_state;

  // Handshake: xfer_req rises with xfer_data stable. The destination raises
  // xfer_ack_async, xfer_req falls, then the ack falls (four-phase, level based).
  modport master (
    output req, req_data, xfer_ack_async,
    input  grant, timeout_err, busy, grant_id, xfer_req, xfer_data, fsm_state
  );

  modport slave (
    input  req, req_data, xfer_ack_async,
    output grant, timeout_err, busy, grant_id, xfer_req, xfer_data, fsm_state
  );
endinterface

// File: rtl/cdc_xfer_scheduler.sv
// Source-domain controller for a shared CDC lane: round-robin arbitration,
// a four-phase req/ack handshake with a synchronised ack, and a timeout abort.
module cdc_xfer_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input logic                  clk,
  input logic                  rst_n,
  cdc_xfer_scheduler_if.slave  bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, SETUP, REQ_HI, REQ_LO, DONE, ABORT} state_t;

  state_t             state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic               ack_sync;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [ID_W-1:0]    rr_ptr, rr_n, next_ptr;
  logic [ID_W-1:0]    id_q, id_n, win_id;
  logic [DATA_W-1:0]  data_q, data_n;
  logic [NUM_REQ-1:0] grant_q, grant_n;
  logic               terr_q, terr_n, busy_q, busy_n, xreq_q, xreq_n;
  logic               win_found;
  logic [ID_W:0]      cand_sum;
  logic [ID_W-1:0]    cand;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.xfer_ack_async};
  end
  assign ack_sync = sync_q[SYNC_STAGES-1];

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(NUM_REQ)) cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      cand = cand_sum[ID_W-1:0];
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign next_ptr = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);

  always_comb begin
    state_n = state;
    grant_n = '0;
    terr_n  = 1'b0;
    xreq_n  = xreq_q;
    id_n    = id_q;
    data_n  = data_q;
    rr_n    = rr_ptr;
    cnt_n   = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        // A still-high ack belongs to no transfer of ours; wait it out.
        if (!ack_sync && win_found) begin
          id_n    = win_id;
          data_n  = bus.req_data[win_id*DATA_W +: DATA_W];
          state_n = SETUP;
        end
      end
      SETUP: begin
        xreq_n  = 1'b1;
        cnt_n   = '0;
        state_n = REQ_HI;
      end
      REQ_HI: begin
        if (ack_sync) begin
          xreq_n  = 1'b0;
          cnt_n   = '0;
          state_n = REQ_LO;
        end else if (cnt == CNT_LAST) begin
          xreq_n  = 1'b0;
          terr_n  = 1'b1;
          state_n = ABORT;
        end
      end
      REQ_LO: begin
        if (!ack_sync) begin
          grant_n[id_q] = 1'b1;
          state_n       = DONE;
        end else if (cnt == CNT_LAST) begin
          terr_n  = 1'b1;
          state_n = ABORT;
        end
      end
      DONE: begin
        rr_n    = next_ptr;
        state_n = IDLE;
      end
      ABORT: begin
        xreq_n = 1'b0;
        rr_n   = next_ptr;
        if (!ack_sync) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      rr_ptr  <= '0;
      id_q    <= '0;
      data_q  <= '0;
      grant_q <= '0;
      terr_q  <= 1'b0;
      busy_q  <= 1'b0;
      xreq_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rr_ptr  <= rr_n;
      id_q    <= id_n;
      data_q  <= data_n;
      grant_q <= grant_n;
      terr_q  <= terr_n;
      busy_q  <= busy_n;
      xreq_q  <= xreq_n;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.timeout_err = terr_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = id_q;
  assign bus.xfer_req    = xreq_q;
  assign bus.xfer_data   = data_q;
  assign bus.fsm_state   = state;
endmodule

// File: doc/cdc_xfer_scheduler.md
Name: cdc_xfer_scheduler

Overview:
- Source-domain controller for a shared clock-domain-crossing channel.
- Round-robin arbitrates NUM_REQ requesters onto one data lane.
- Runs a four-phase req/ack handshake with the destination domain; the returning ack passes through an internal SYNC_STAGES-deep synchronizer.
- Aborts on a timeout so that a dead destination clock cannot hang the requesters.

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 8: payload width.
- SYNC_STAGES, 2: flops in the ack synchronizer chain (>=2).
- TIMEOUT, 255: maximum cycles spent waiting in a handshake phase before aborting (1..65535).

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester transfer request, level.
- req_data  in  NUM_REQ*DATA_W  payload; requester i owns slice [i*DATA_W +: DATA_W].
- grant  out  NUM_REQ  one-hot, 1-cycle pulse: transfer for requester i completed.
- timeout_err  out  1  1-cycle pulse: current transfer aborted.
- busy  out  1  high in every state except IDLE.
- grant_id  out  $clog2(NUM_REQ)  index of requester being served.
- xfer_req  out  1  handshake request to destination domain.
- xfer_data  out  DATA_W  payload to destination; stable while xfer_req=1.
- xfer_ack_async  in  1  destination ack, asynchronous to clk.

Behaviour:
- All outputs registered. Reset values: grant=0, timeout_err=0, busy=0, grant_id=0, xfer_req=0, xfer_data=0. Reset also clears the synchronizer chain, the RR pointer and the timeout counter.
- ack_sync is the last stage of the SYNC_STAGES chain clocked by clk.
- States: IDLE, SETUP, REQ_HI, REQ_LO, DONE, ABORT.
- IDLE:
  - If any req=1 and ack_sync=0, pick a winner round-robin.
  - Search starts at (last_served+1) mod NUM_REQ; after reset it starts at index 0.
  - Latch grant_id and xfer_data from the winner's slice, then go to SETUP.
  - If ack_sync=1, stay in IDLE (stale ack guard).
- SETUP: one cycle with data stable; set xfer_req=1; go to REQ_HI.
- REQ_HI:
  - Wait for ack_sync=1.
  - When ack_sync=1: xfer_req=0, go to REQ_LO.
  - Counter reaches TIMEOUT: go to ABORT.
- REQ_LO:
  - Wait for ack_sync=0, then go to DONE and pulse grant[grant_id].
  - Counter reaches TIMEOUT: go to ABORT.
- DONE: grant returns to 0; last_served=grant_id; go to IDLE.
- ABORT:
  - Forces xfer_req=0.
  - Pulses timeout_err on entry only.
  - Sets last_served=grant_id; no grant pulse.
  - Stays in ABORT (busy=1) until ack_sync=0, then goes to IDLE. No timeout applies in ABORT.
- Timeout counter: cleared on entry to REQ_HI and REQ_LO; increments every cycle in those states. Width is $clog2(TIMEOUT+1) and it saturates, never wraps.
- xfer_data and grant_id hold from SETUP through DONE/ABORT. req_data changes after the IDLE latch are ignored.
- A requester holds req until its grant or timeout_err. If req drops mid-transfer, the transfer still completes and grant still pulses.
- Simultaneous requests: exactly one winner per arbitration. A requester that keeps req high is served again only after every other active requester has had a turn.
- Latency: with xfer_ack_async tied to xfer_req and SYNC_STAGES=2:
  - req sampled at edge 0;
  - xfer_req high after edge 1;
  - xfer_req low after edge 4;
  - grant pulse after edge 7;
  - IDLE after edge 8;
  - next arbitration at edge 9.
  Back-to-back period is 9 cycles. Each extra sync stage adds 2 cycles.
- Reset asserted mid-transfer: all outputs drop to reset values immediately; no grant or timeout_err is emitted.

Test Plan:
- Reset, then req=4'b0001, req_data[7:0]=8'hA5, ack looped back: xfer_data=8'hA5 after edge 0, xfer_req high after edge 1, grant=4'b0001 pulse after edge 7, busy=0 after edge 8.
- req=4'b1111 held continuously, loopback ack: grant order 0,1,2,3,0, pulses spaced 9 cycles apart, grant_id matches each pulse.
- xfer_ack_async tied 0, TIMEOUT=16: xfer_req drops and timeout_err pulses once, 16 cycles after REQ_HI entry. No grant. Next arbitration serves the next index.
- ack rises then sticks high, TIMEOUT=16: REQ_LO times out and enters ABORT with busy=1 held. Releasing ack returns to IDLE 3 cycles later. No new xfer_req while ack_sync=1.
- Requester 2 drops req in REQ_HI and req_data changes: xfer_data unchanged, grant=4'b0100 still pulses.
- rst_n asserted in REQ_LO: xfer_req, busy, grant_id and xfer_data go to 0 asynchronously. After release, req=4'b1000 is served with RR restarted from index 0.
